// File: rtl/ysyx_22050039_mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter, one outstanding txn.
// Ports: clk, rst (async active-low); ifu_req_*/ifu_resp_*/ifu_rdata;
//   lsu_req_*/lsu_resp_*/lsu_rdata; mem_req_*/mem_addr/mem_w*/mem_resp_*;
//   busy. Macro YSYX_22050039_ARB_RR_EN selects round-robin on ties,
//   otherwise LSU wins ties (fixed priority).
module ysyx_22050039_mem_arbiter #(
    parameter int XLEN   = 64,
    parameter int MASK_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [XLEN-1:0]   ifu_addr,
    output logic              ifu_resp_valid,
    output logic [XLEN-1:0]   ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [XLEN-1:0]   lsu_addr,
    input  logic              lsu_wen,
    input  logic [XLEN-1:0]   lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [XLEN-1:0]   lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner;
    logic                r_last_grant;
    logic [XLEN-1:0]     r_addr;
    logic                r_wen;
    logic [XLEN-1:0]     r_wdata;
    logic [MASK_W-1:0]   r_wmask;
    logic [XLEN-1:0]     r_ifu_rdata;
    logic [XLEN-1:0]     r_lsu_rdata;
    logic                r_ifu_resp;
    logic                r_lsu_resp;
    logic                w_tie_lsu;
    logic                w_grant_lsu;
    logic                w_accept;
    logic                w_done;

`ifdef YSYX_22050039_ARB_RR_EN
    // On a tie, hand the port to whoever did not finish last.
    assign w_tie_lsu = (r_last_grant == OWN_IFU);
`else
    // Fixed priority: LSU always wins a tie; last_grant only tracked.
    assign w_tie_lsu = r_last_grant | 1'b1;
`endif

    assign w_grant_lsu = lsu_req_valid & (~ifu_req_valid | w_tie_lsu);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        w_accept      = 1'b0;
        w_done        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // rst gating keeps readies low while reset is held.
                ifu_req_ready = rst & ifu_req_valid & ~w_grant_lsu;
                lsu_req_ready = rst & w_grant_lsu;
                w_accept      = ifu_req_ready | lsu_req_ready;
                if (w_accept) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner      <= OWN_IFU;
            r_last_grant <= OWN_LSU;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_ifu_rdata  <= '0;
            r_lsu_rdata  <= '0;
            r_ifu_resp   <= 1'b0;
            r_lsu_resp   <= 1'b0;
        end else begin
            r_ifu_resp <= w_done & (r_owner == OWN_IFU);
            r_lsu_resp <= w_done & (r_owner == OWN_LSU);
            if (w_accept) begin
                r_owner <= w_grant_lsu;
                if (w_grant_lsu) begin
                    r_addr  <= lsu_addr;
                    r_wen   <= lsu_wen;
                    r_wdata <= lsu_wdata;
                    r_wmask <= lsu_wmask;
                end else begin
                    r_addr  <= ifu_addr;
                    r_wen   <= 1'b0;
                    r_wdata <= '0;
                    r_wmask <= '0;
                end
            end
            if (w_done) begin
                r_last_grant <= r_owner;
                if (r_owner == OWN_LSU) begin
                    r_lsu_rdata <= mem_rdata;
                end else begin
                    r_ifu_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr       = r_addr;
    assign mem_wen        = r_wen;
    assign mem_wdata      = r_wdata;
    assign mem_wmask      = r_wmask;
    assign ifu_rdata      = r_ifu_rdata;
    assign lsu_rdata      = r_lsu_rdata;
    assign ifu_resp_valid = r_ifu_resp;
    assign lsu_resp_valid = r_lsu_resp;
    assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_ysyx_22050039_mem_arbiter.sv
// Directed testbench for ysyx_22050039_mem_arbiter.
// Scoreboard queue of expected responses, immediate-assertion checks.
module tb_ysyx_22050039_mem_arbiter;

    localparam int XLEN   = 64;
    localparam int MASK_W = XLEN / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [XLEN-1:0]   ifu_addr;
    logic              ifu_resp_valid;
    logic [XLEN-1:0]   ifu_rdata;
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [XLEN-1:0]   lsu_addr;
    logic              lsu_wen;
    logic [XLEN-1:0]   lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_resp_valid;
    logic [XLEN-1:0]   lsu_rdata;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [XLEN-1:0]   mem_addr;
    logic              mem_wen;
    logic [XLEN-1:0]   mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp_valid;
    logic [XLEN-1:0]   mem_rdata;
    logic              busy;

    ysyx_22050039_mem_arbiter #(.XLEN(XLEN), .MASK_W(MASK_W)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid),
        .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            owner;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;
    int   n_lsu_resp = 0;
    logic last_g;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic own, input logic [XLEN-1:0] d);
        exp_t e;
        e.owner = own;
        e.data  = d;
        sb.push_back(e);
    endtask

    // Advance one cycle and score any response pulse.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        chk("resp_onehot", {63'b0, ifu_resp_valid & lsu_resp_valid}, 64'd0);
        if (lsu_resp_valid) n_lsu_resp++;
        if (ifu_resp_valid || lsu_resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_owner", {63'b0, lsu_resp_valid}, {63'b0, e.owner});
                chk("resp_data", lsu_resp_valid ? lsu_rdata : ifu_rdata,
                    e.data);
            end
        end
    endtask

    // Expect grant to own now, then serve with minimum latency.
    task automatic grant_serve(input logic own, input logic [XLEN-1:0] addr,
                               input logic wen, input logic [XLEN-1:0] d,
                               input logic keep);
        #1;
        chk("ifu_ready", {63'b0, ifu_req_ready}, {63'b0, !own});
        chk("lsu_ready", {63'b0, lsu_req_ready}, {63'b0, own});
        push_exp(own, d);
        tick();
        if (!keep) begin
            if (own) lsu_req_valid = 1'b0;
            else     ifu_req_valid = 1'b0;
        end
        chk("req_valid_T1", {63'b0, mem_req_valid}, 64'd1);
        chk("mem_addr_T1", mem_addr, addr);
        chk("mem_wen_T1", {63'b0, mem_wen}, {63'b0, wen});
        chk("ready_in_req", {63'b0, ifu_req_ready | lsu_req_ready}, 64'd0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("req_valid_wait", {63'b0, mem_req_valid}, 64'd0);
        mem_resp_valid = 1'b1;
        mem_rdata      = d;
        tick();
        mem_resp_valid = 1'b0;
        chk("pulse_T3", {63'b0, own ? lsu_resp_valid : ifu_resp_valid},
            64'd1);
        last_g = own;
    endtask

    function automatic logic tie_winner(input logic lg);
`ifdef YSYX_22050039_ARB_RR_EN
        return !lg;
`else
        return lg | 1'b1;
`endif
    endfunction

    initial begin
        logic w;
        rst = 1'b0;
        ifu_req_valid = 0; ifu_addr = '0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0;
        lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
        last_g = 1'b1;
        tick();
        tick();
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_mreq", {63'b0, mem_req_valid}, 64'd0);
        chk("rst_maddr", mem_addr, 64'd0);
        chk("rst_ifu_rdata", ifu_rdata, 64'd0);
        chk("rst_lsu_rdata", lsu_rdata, 64'd0);
        rst = 1'b1;
        tick();

        // IFU-only read.
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_0000;
        grant_serve(1'b0, 64'h8000_0000, 1'b0, 64'h413, 1'b0);
        chk("ifu_rdata", ifu_rdata, 64'h413);
        chk("lsu_quiet", {63'b0, lsu_resp_valid}, 64'd0);
        tick();
        chk("ifu_pulse_once", {63'b0, ifu_resp_valid}, 64'd0);
        chk("ifu_rdata_hold", ifu_rdata, 64'h413);

        // LSU store with three request stalls.
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b1;
        lsu_addr      = 64'h8000_1000;
        lsu_wdata     = 64'hDEAD_BEEF;
        lsu_wmask     = 8'h0F;
        #1;
        chk("st_ready", {63'b0, lsu_req_ready}, 64'd1);
        push_exp(1'b1, 64'h55);
        tick();
        lsu_req_valid = 1'b0;
        lsu_addr      = 64'h1234;
        lsu_wdata     = 64'h0;
        lsu_wmask     = 8'hFF;
        lsu_wen       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("st_mreq", {63'b0, mem_req_valid}, 64'd1);
            chk("st_wen", {63'b0, mem_wen}, 64'd1);
            chk("st_wmask", {56'b0, mem_wmask}, 64'h0F);
            chk("st_wdata", mem_wdata, 64'hDEAD_BEEF);
            chk("st_addr", mem_addr, 64'h8000_1000);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("st_wait_busy", {63'b0, busy}, 64'd1);
            tick();
        end
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h55;
        tick();
        mem_resp_valid = 1'b0;
        last_g = 1'b1;
        tick();
        tick();
        chk("st_pulse_count", n_lsu_resp, 1);
        chk("st_ifu_rdata_hold", ifu_rdata, 64'h413);

        // Three back-to-back tie rounds, then IFU alone.
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_0100;
        lsu_req_valid = 1'b1;
        lsu_addr      = 64'h8000_2000;
        for (int r = 0; r < 3; r++) begin
            w = tie_winner(last_g);
            grant_serve(w, w ? 64'h8000_2000 : 64'h8000_0100, 1'b0,
                        64'hA0 + r, 1'b1);
        end
        lsu_req_valid = 1'b0;
        grant_serve(1'b0, 64'h8000_0100, 1'b0, 64'hB0, 1'b0);
        tick();

        // Reset while in WAIT.
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_3000;
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("wait_busy", {63'b0, busy}, 64'd1);
        rst = 1'b0;
        #1;
        chk("rr_busy", {63'b0, busy}, 64'd0);
        chk("rr_mreq", {63'b0, mem_req_valid}, 64'd0);
        chk("rr_ifu_ready", {63'b0, ifu_req_ready}, 64'd0);
        chk("rr_lsu_ready", {63'b0, lsu_req_ready}, 64'd0);
        tick();
        ifu_req_valid  = 1'b0;
        rst            = 1'b1;
        last_g         = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hBAD;
        tick();
        mem_resp_valid = 1'b0;
        tick();
        chk("rr_no_resp", {63'b0, ifu_resp_valid}, 64'd0);

        // Spurious response in IDLE, then addr change during REQ stall.
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        chk("sp_busy", {63'b0, busy}, 64'd0);
        tick();
        chk("sp_no_resp", {63'b0, ifu_resp_valid | lsu_resp_valid}, 64'd0);
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_4000;
        push_exp(1'b0, 64'hC0);
        tick();
        ifu_req_valid = 1'b0;
        ifu_addr      = 64'h8000_5000;
        for (int i = 0; i < 2; i++) begin
            chk("sp_addr_hold", mem_addr, 64'h8000_4000);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hC0;
        tick();
        mem_resp_valid = 1'b0;
        tick();

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
